// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared PS/2 definitions: transmit state encoding, keyboard
//            command bytes, default timing constants and a parity helper.
//            Used by both the receive and the transmit shifters.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Host-to-device transmit sequencer states
    typedef enum logic [2:0] {
        PS2_TX_IDLE      = 3'd0,
        PS2_TX_INHIBIT   = 3'd1,
        PS2_TX_REQUEST   = 3'd2,
        PS2_TX_DATA      = 3'd3,
        PS2_TX_PARITY    = 3'd4,
        PS2_TX_STOP      = 3'd5,
        PS2_TX_WAIT_IDLE = 3'd6
    } ps2_tx_state_t;

    // Common keyboard commands
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    // Default timing at a 12.5 MHz CPU clock: 100 us inhibit, 20 ms timeout
    localparam int PS2_INHIBIT_CYCLES_DEFAULT = 1250;
    localparam int PS2_TIMEOUT_CYCLES_DEFAULT = 250000;

    // Number of data bits in a PS/2 frame
    localparam int PS2_DATA_BITS = 8;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd
    function automatic logic ps2_odd_parity(input logic [7:0] value);
        return ~^value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module   : ps2_tx_shifter
// Brief    : PS/2 host-to-device transmitter. A bus write of a command byte
//            starts the request-to-send sequence (clock inhibit, start bit,
//            clock release), then shifts data, parity and stop bits out on
//            falling device clock edges and checks the device ACK. Line
//            drivers are pull-low enables; the tristates live at board level.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_tx_shifter
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_DEFAULT,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cs,
    input  logic        write,
    input  logic [31:0] data_in,
    input  logic        edge_found,
    input  logic        ps2_data_sync,
    input  logic        ps2_clock_sync,
    output logic        ps2_clock_oe,
    output logic        ps2_data_oe,
    output logic        transmitting,
    output logic        done,
    output logic        ack_error,
    output logic        timeout_error
);

    // INHIBIT_CYCLES must be at least 1 so the counter has a non-zero width
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [INH_W-1:0] INH_LAST    = INH_W'(INHIBIT_CYCLES);
    localparam logic [INH_W-1:0] INH_PRELAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT    = TO_W'(TIMEOUT_CYCLES);
    localparam logic [3:0]       LAST_BIT    = 4'(PS2_DATA_BITS);

    // Registered state
    ps2_tx_state_t    state;
    logic [7:0]       shift;
    logic             parity;
    logic [3:0]       bit_count;
    logic [INH_W-1:0] inhibit_count;
    logic [TO_W-1:0]  timeout_count;
    logic             ack_fail;

    // Next-state values
    ps2_tx_state_t    state_next;
    logic [7:0]       shift_next;
    logic             parity_next;
    logic [3:0]       bit_count_next;
    logic [INH_W-1:0] inhibit_count_next;
    logic [TO_W-1:0]  timeout_count_next;
    logic             ack_fail_next;
    logic             clock_oe_next;
    logic             data_oe_next;
    logic             transmitting_next;
    logic             done_next;
    logic             ack_error_next;
    logic             timeout_error_next;

    logic             write_accept;

    // Only the top byte of the bus word carries the command
    logic             unused_data_bits;
    assign unused_data_bits = ^data_in[23:0];

    assign write_accept = cs & write;

    // State and output registers; reset releases both lines at once
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= PS2_TX_IDLE;
            shift         <= '0;
            parity        <= 1'b0;
            bit_count     <= '0;
            inhibit_count <= '0;
            timeout_count <= '0;
            ack_fail      <= 1'b0;
            ps2_clock_oe  <= 1'b0;
            ps2_data_oe   <= 1'b0;
            transmitting  <= 1'b0;
            done          <= 1'b0;
            ack_error     <= 1'b0;
            timeout_error <= 1'b0;
        end else begin
            state         <= state_next;
            shift         <= shift_next;
            parity        <= parity_next;
            bit_count     <= bit_count_next;
            inhibit_count <= inhibit_count_next;
            timeout_count <= timeout_count_next;
            ack_fail      <= ack_fail_next;
            ps2_clock_oe  <= clock_oe_next;
            ps2_data_oe   <= data_oe_next;
            transmitting  <= transmitting_next;
            done          <= done_next;
            ack_error     <= ack_error_next;
            timeout_error <= timeout_error_next;
        end
    end

    // Next-state and next-output logic for the request-to-send sequence
    always_comb begin
        state_next         = state;
        shift_next         = shift;
        parity_next        = parity;
        bit_count_next     = bit_count;
        inhibit_count_next = inhibit_count;
        timeout_count_next = timeout_count;
        ack_fail_next      = ack_fail;
        clock_oe_next      = ps2_clock_oe;
        data_oe_next       = ps2_data_oe;
        done_next          = 1'b0;
        ack_error_next     = ack_error;
        timeout_error_next = timeout_error;

        case (state)
            PS2_TX_IDLE: begin
                clock_oe_next = 1'b0;
                data_oe_next  = 1'b0;
                if (write_accept) begin
                    shift_next         = data_in[31:24];
                    parity_next        = ps2_odd_parity(data_in[31:24]);
                    ack_error_next     = 1'b0;
                    timeout_error_next = 1'b0;
                    ack_fail_next      = 1'b0;
                    bit_count_next     = '0;
                    timeout_count_next = '0;
                    // Counts inhibit cycles starting from 1 on the first one
                    inhibit_count_next = INH_W'(1);
                    clock_oe_next      = 1'b1;
                    // A one-cycle inhibit already needs the start bit
                    data_oe_next       = (INHIBIT_CYCLES <= 1);
                    state_next         = PS2_TX_INHIBIT;
                end
            end

            PS2_TX_INHIBIT: begin
                if (inhibit_count >= INH_LAST) begin
                    // Release the clock while holding the start bit low
                    clock_oe_next      = 1'b0;
                    data_oe_next       = 1'b1;
                    timeout_count_next = TO_W'(1);
                    state_next         = PS2_TX_REQUEST;
                end else begin
                    inhibit_count_next = inhibit_count + INH_W'(1);
                    if (inhibit_count == INH_PRELAST) begin
                        data_oe_next = 1'b1;
                    end
                end
            end

            default: begin
                // REQUEST through WAIT_IDLE: timeout wins over a same-cycle edge
                if (timeout_count >= TO_LIMIT) begin
                    clock_oe_next      = 1'b0;
                    data_oe_next       = 1'b0;
                    timeout_error_next = 1'b1;
                    done_next          = 1'b1;
                    state_next         = PS2_TX_IDLE;
                end else begin
                    timeout_count_next = timeout_count + TO_W'(1);
                    case (state)
                        PS2_TX_REQUEST: begin
                            if (edge_found) begin
                                data_oe_next   = ~shift[0];
                                bit_count_next = 4'd1;
                                state_next     = PS2_TX_DATA;
                            end
                        end
                        PS2_TX_DATA: begin
                            if (edge_found) begin
                                if (bit_count == LAST_BIT) begin
                                    data_oe_next = ~parity;
                                    state_next   = PS2_TX_PARITY;
                                end else begin
                                    data_oe_next   = ~shift[bit_count[2:0]];
                                    bit_count_next = bit_count + 4'd1;
                                end
                            end
                        end
                        PS2_TX_PARITY: begin
                            if (edge_found) begin
                                // Stop bit: let the pull-up drive the line high
                                data_oe_next = 1'b0;
                                state_next   = PS2_TX_STOP;
                            end
                        end
                        PS2_TX_STOP: begin
                            if (edge_found) begin
                                // Device ACKs by holding data low at this edge
                                ack_fail_next = ps2_data_sync;
                                state_next    = PS2_TX_WAIT_IDLE;
                            end
                        end
                        PS2_TX_WAIT_IDLE: begin
                            if (ps2_clock_sync && ps2_data_sync) begin
                                ack_error_next = ack_fail;
                                done_next      = 1'b1;
                                clock_oe_next  = 1'b0;
                                data_oe_next   = 1'b0;
                                state_next     = PS2_TX_IDLE;
                            end
                        end
                        default: begin
                            clock_oe_next = 1'b0;
                            data_oe_next  = 1'b0;
                            state_next    = PS2_TX_IDLE;
                        end
                    endcase
                end
            end
        endcase

        transmitting_next = (state_next != PS2_TX_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_tx_shifter
// Brief    : Self-checking bench for ps2_tx_shifter with a PS/2 keyboard
//            model, a frame/result scoreboard and randomized command bytes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_tx_shifter;
    import ps2_pkg::*;

    localparam int INH        = 10;
    localparam int TMO        = 2000;
    localparam int DEV_PERIOD = 40;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs = 1'b0;
    logic        write = 1'b0;
    logic [31:0] data_in = '0;
    logic        edge_found = 1'b0;
    logic        ps2_data_sync = 1'b1;
    logic        ps2_clock_sync = 1'b1;
    logic        ps2_clock_oe;
    logic        ps2_data_oe;
    logic        transmitting;
    logic        done;
    logic        ack_error;
    logic        timeout_error;

    always #5 clk = ~clk;

    ps2_tx_shifter #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock          (clk),
        .reset          (reset_n),
        .cs             (cs),
        .write          (write),
        .data_in        (data_in),
        .edge_found     (edge_found),
        .ps2_data_sync  (ps2_data_sync),
        .ps2_clock_sync (ps2_clock_sync),
        .ps2_clock_oe   (ps2_clock_oe),
        .ps2_data_oe    (ps2_data_oe),
        .transmitting   (transmitting),
        .done           (done),
        .ack_error      (ack_error),
        .timeout_error  (timeout_error)
    );

    typedef struct {
        logic ack;
        logic tmo;
    } result_t;

    int          errors = 0;
    int          checks = 0;
    result_t     exp_res_q[$];
    logic [10:0] exp_frame_q[$];
    logic [10:0] obs_frame_q[$];
    bit          dev_clocking = 1'b1;
    bit          dev_acks = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Wire-order frame: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = ((int'(b) >> i) % 2) == 1;
            ones += (int'(b) >> i) % 2;
        end
        f[9]  = (ones % 2) == 0;
        f[10] = 1'b1;
        return f;
    endfunction

    // Keyboard model: clocks 11 falling edges every DEV_PERIOD cycles once
    // the host releases clock with data low, samples the line before each
    // edge, and optionally ACKs by pulling data low at the 11th edge
    initial begin : device
        int          dcnt;
        int          nedges;
        int          clk_low;
        int          ack_hold;
        bit          active;
        logic [10:0] bits;
        dcnt = 0; nedges = 0; clk_low = 0; ack_hold = 0; active = 1'b0; bits = '0;
        forever begin
            @(negedge clk);
            edge_found = 1'b0;
            if (!reset_n) begin
                dcnt = 0; nedges = 0; clk_low = 0; ack_hold = 0; active = 1'b0;
            end else begin
                if (clk_low > 0) clk_low--;
                if (ack_hold > 0) ack_hold--;
                if (!active) begin
                    if (dev_clocking && transmitting && !ps2_clock_oe && ps2_data_oe) begin
                        active = 1'b1; dcnt = 0; nedges = 0;
                    end
                end else if (nedges < 11) begin
                    dcnt++;
                    if (dcnt == DEV_PERIOD) begin
                        dcnt = 0;
                        bits[nedges] = ~ps2_data_oe;
                        nedges++;
                        edge_found = 1'b1;
                        clk_low = DEV_PERIOD / 2;
                        if (nedges == 11) begin
                            obs_frame_q.push_back(bits);
                            if (dev_acks) ack_hold = 25;
                        end
                    end
                end else if (clk_low == 0 && ack_hold == 0) begin
                    active = 1'b0;
                end
            end
            ps2_clock_sync = !ps2_clock_oe && (clk_low == 0);
            ps2_data_sync  = !ps2_data_oe && (ack_hold == 0);
        end
    end

    // Scoreboard monitor: checks results on done and frames as the device completes them
    initial begin : monitor
        result_t     r;
        logic [10:0] o;
        bit          prev_done;
        prev_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (prev_done) check("done_one_cycle", done, 1'b0);
            prev_done = reset_n && done;
            if (reset_n && done) begin
                if (exp_res_q.size() == 0) begin
                    check("unexpected_done", done, 1'b0);
                end else begin
                    r = exp_res_q.pop_front();
                    check("ack_error_at_done", ack_error, r.ack);
                    check("timeout_error_at_done", timeout_error, r.tmo);
                    check("idle_at_done", {transmitting, ps2_clock_oe, ps2_data_oe}, 3'b000);
                end
            end
            while (obs_frame_q.size() > 0) begin
                o = obs_frame_q.pop_front();
                if (exp_frame_q.size() == 0) check("unexpected_frame", o, 11'h7FF ^ o);
                else check("frame", o, exp_frame_q.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit acks, input bit clocks, input bit intrude);
        int waited;
        dev_acks = acks;
        dev_clocking = clocks;
        if (clocks) begin
            exp_frame_q.push_back(ref_frame(b));
            exp_res_q.push_back('{ack: !acks, tmo: 1'b0});
        end else begin
            exp_res_q.push_back('{ack: 1'b0, tmo: 1'b1});
        end
        @(negedge clk);
        cs = 1'b1; write = 1'b1; data_in = {b, 24'($urandom)};
        @(negedge clk);
        cs = 1'b0; write = 1'b0; data_in = $urandom;
        check("busy_after_write", {transmitting, ps2_clock_oe}, 2'b11);
        check("errors_cleared", {ack_error, timeout_error}, 2'b00);
        repeat (INH - 2) @(negedge clk);
        check("data_oe_before_start", ps2_data_oe, 1'b0);
        @(negedge clk);
        check("start_bit", {ps2_clock_oe, ps2_data_oe}, 2'b11);
        @(negedge clk);
        check("clock_release", {ps2_clock_oe, ps2_data_oe}, 2'b01);
        if (!clocks) begin
            repeat (TMO - 1) @(negedge clk);
            check("no_early_timeout", {transmitting, timeout_error}, 2'b10);
            @(negedge clk);
            check("timeout_state", {timeout_error, transmitting, ps2_clock_oe, ps2_data_oe}, 4'b1000);
        end else begin
            if (intrude) begin
                repeat (200) @(negedge clk);
                cs = 1'b1; write = 1'b1; data_in = {8'hAA, 24'h0};
                @(negedge clk);
                cs = 1'b0; write = 1'b0;
            end
            waited = 0;
            while (transmitting && waited < 5000) begin
                @(negedge clk);
                waited++;
            end
            check("transfer_finished", transmitting, 1'b0);
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin : stimulus
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {ps2_clock_oe, ps2_data_oe, transmitting, done, ack_error, timeout_error}, 6'h0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        send(PS2_CMD_SET_LEDS, 1'b1, 1'b1, 1'b0);
        send(8'h01, 1'b1, 1'b1, 1'b0);
        send(PS2_CMD_RESET, 1'b0, 1'b1, 1'b0);
        send(8'hF4, 1'b1, 1'b0, 1'b0);
        send(PS2_CMD_SET_LEDS, 1'b1, 1'b1, 1'b1);

        // Reset in the middle of DATA, while bit 1 (a zero) holds data low
        dev_clocking = 1'b1; dev_acks = 1'b1;
        @(negedge clk);
        cs = 1'b1; write = 1'b1; data_in = {PS2_CMD_SET_LEDS, 24'h0};
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
        repeat (INH + 90) @(negedge clk);
        check("data_low_before_reset", {transmitting, ps2_clock_oe, ps2_data_oe}, 3'b101);
        #2 reset_n = 1'b0;
        #1;
        check("reset_releases_lines", {ps2_clock_oe, ps2_data_oe, transmitting, done}, 4'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        send(PS2_CMD_SET_LEDS, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            send(8'($urandom), ($urandom_range(0, 3) != 0), 1'b1, 1'b0);
        end

        repeat (20) @(negedge clk);
        check("scoreboard_drained", exp_res_q.size() + exp_frame_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_tx_shifter.md
# ps2_tx_shifter

Host-to-device PS/2 transmitter: the partner of the PS/2 receive path. It sends one command byte to the keyboard, for example 0xED to set the LEDs or 0xFF to reset, using the standard PS/2 host request-to-send sequence. It sits on the CPU bus at a new memory-mapped register beside the PS/2 status and scancode registers. It drives the open-drain `ps2a_clock` and `ps2a_data` lines through pull-low enables and takes falling-clock pulses from the existing edge finder. While `transmitting` is high, the top level gates the receiver's `edge_found`.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 1250: clock-low inhibit period in `clock` cycles (100 µs at 12.5 MHz).
- `TIMEOUT_CYCLES`, default 250000: maximum time from clock release to completion (20 ms).

Ports:
- `clock`  in  1  CPU clock.
- `reset`  in  1  asynchronous, active-low reset.
- `cs`  in  1  register select for the transmit register.
- `write`  in  1  bus write strobe.
- `data_in`  in  32  bus write data; the byte to send is in `[31:24]`.
- `edge_found`  in  1  one-cycle pulse per synchronised PS/2 clock falling edge.
- `ps2_data_sync`  in  1  synchronised level of the PS/2 data line.
- `ps2_clock_sync`  in  1  synchronised level of the PS/2 clock line.
- `ps2_clock_oe`  out  1  1 = pull the PS/2 clock line low.
- `ps2_data_oe`  out  1  1 = pull the PS/2 data line low.
- `transmitting`  out  1  high from the accepted write until the return to IDLE.
- `done`  out  1  one-cycle pulse on a completed transfer, whether it succeeded or failed.
- `ack_error`  out  1  sticky; the device did not pull data low at the ACK clock.
- `timeout_error`  out  1  sticky; the transfer exceeded `TIMEOUT_CYCLES`.

## Operation
- Reset values: all outputs 0, state IDLE, counters 0.
- Accepted write (`cs & write` in IDLE):
  - latch `data_in[31:24]` into `shift`;
  - `parity = ~^data_in[31:24]` (odd parity);
  - clear `ack_error` and `timeout_error`;
  - enter INHIBIT.
- Write in any state other than IDLE: ignored; the registers and the transfer are untouched.
- `ps2_data_oe = ~bit` whenever a bit is being presented.
- States and transitions:
  - IDLE: both output enables 0.
  - INHIBIT: `ps2_clock_oe = 1`; count `INHIBIT_CYCLES`.
    - In the final cycle, also set `ps2_data_oe = 1` (start bit 0).
    - Then go to REQUEST.
  - REQUEST: `ps2_clock_oe = 0`, `ps2_data_oe = 1`; start the timeout counter. On `edge_found`, present `shift[0]` and go to DATA with `bit_count = 1`.
  - DATA: on each `edge_found`, present `shift[bit_count]` and increment `bit_count`.
    - When `bit_count == 8`, present `parity` instead and go to PARITY.
  - PARITY: on `edge_found`, release data (stop bit = 1) and go to STOP.
  - STOP: on `edge_found` (the 11th edge), sample `ps2_data_sync`.
    - Sampled 1: set `ack_error`.
    - Either way, go to WAIT_IDLE.
  - WAIT_IDLE: when `ps2_clock_sync & ps2_data_sync` is true, pulse `done` and go to IDLE.
- Timeout: the counter runs in REQUEST through WAIT_IDLE. On reaching `TIMEOUT_CYCLES`:
  - release both lines;
  - set `timeout_error`;
  - pulse `done`;
  - go to IDLE.
- Timeout takes precedence over `edge_found` arriving in the same cycle.
- `edge_found` in IDLE or INHIBIT: ignored.

## Timing
- Accepted write at cycle N: `transmitting` and `ps2_clock_oe` are high at N+1.
- `ps2_data_oe` rises at N+`INHIBIT_CYCLES`.
- `ps2_clock_oe` falls at N+`INHIBIT_CYCLES`+1.
- Each data line change is registered one cycle after its `edge_found` pulse.
- `done` is high for exactly one cycle; `transmitting` falls in the same cycle as the `done` pulse, on return to IDLE.
- The error flags update in the same cycle as the `done` pulse and hold until the next accepted write.
- Counter widths are `$clog2(param+1)`. Counters saturate and do not wrap.
- Asynchronous reset mid-transfer: both lines released immediately (combinationally via reset on the registered enables), state IDLE, no `done` pulse.

## Structure
- Shared package `ps2_pkg` holds:
  - the state encoding (`PS2_TX_IDLE` … `PS2_TX_WAIT_IDLE`);
  - the command constants (`PS2_CMD_SET_LEDS` = 0xED, `PS2_CMD_RESET` = 0xFF);
  - the default timing constants.
- The receive shifter also uses `ps2_pkg`.
- No sub-module: edge detection is reused from the existing `ps2_edge_finder` instance.
- The tristate assignments stay at board level.

## Test plan
All scenarios use `INHIBIT_CYCLES` = 10 and `TIMEOUT_CYCLES` = 2000, with a bench device model that clocks every 40 cycles.
- Write 0xED:
  - data bits presented are 1,0,1,1,0,1,1,1 (LSB first), then parity 1, then stop (released);
  - the model ACKs;
  - expect `done` pulse, `ack_error` = 0, `timeout_error` = 0.
- Write 0x01: parity presented = 0; full frame 0,1,0,0,0,0,0,0,0,0,1 matches as seen by the device model.
- Write 0xFF with the device model not ACKing (data high at the 11th edge): expect `ack_error` = 1 at the `done` pulse, and `ack_error` cleared by the next write.
- Write 0xF4 with the device never clocking:
  - `timeout_error` = 1 exactly 2000 cycles after the clock release;
  - both output enables 0;
  - `transmitting` = 0.
- Second write of 0xAA in mid-frame of a 0xED transfer: ignored; the 0xED frame completes bit-exact.
- `reset` asserted low during DATA: `ps2_clock_oe` = `ps2_data_oe` = 0 immediately, no `done` pulse; a subsequent write of 0xED completes normally.
